frame_arbiter: RTL

FRAME_ARBITER -- requirements
Module: frame_arbiter

---
 rtl/frame_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/frame_arbiter.sv
// Round-robin arbiter that hands one framer to N_REQ byte-stream requesters,
// pacing bytes against a credit count refilled by the framer's serial output.
module frame_arbiter #(
  parameter int N_REQ    = 4,
  parameter int BUFF_L   = 10,
  parameter int HDR_BITS = 80,
  parameter int MAX_LEN  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     grant,
  output logic                 frame_en,
  input  logic                 frame_ready,
  input  logic                 tx_valid,
  output logic [7:0]           fr_data,
  output logic                 fr_data_valid,
  output logic                 trunc
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CR_W  = $clog2(BUFF_L + 1);
  localparam int BC_W  = $clog2(MAX_LEN + 1);
  localparam int BIT_W = 16;
  localparam logic [CR_W-1:0]  CRED_MAX = CR_W'(BUFF_L);
  localparam logic [BC_W-1:0]  LEN_MAX  = BC_W'(MAX_LEN);
  localparam logic [BIT_W-1:0] HDR      = BIT_W'(HDR_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, START, STREAM, DRAIN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  g_idx;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  cand;
  logic [CR_W-1:0]   credits;
  logic [BC_W-1:0]   byte_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  bit_nxt;
  logic              credit_ret;

  // Scan downward so the nearest valid requester at or after rr_ptr wins.
  always_comb begin
    pick_idx = rr_ptr;
    cand     = rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (req_valid[cand]) pick_idx = cand;
    end
  end

  always_comb begin
    fr_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) fr_data = req_data[8*i +: 8];
    end
  end

  assign fr_data_valid = (state == STREAM) && req_valid[g_idx] && (credits != '0);
  assign req_ready     = grant & {N_REQ{fr_data_valid}};

  // One credit per serialised byte once the preamble/SFD bits have gone out.
  assign bit_nxt    = bit_cnt + BIT_W'(1);
  assign credit_ret = (state != IDLE) && tx_valid && (bit_nxt > HDR) &&
                      (bit_nxt[2:0] == HDR[2:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      g_idx    <= '0;
      rr_ptr   <= '0;
      frame_en <= 1'b0;
      trunc    <= 1'b0;
      credits  <= CRED_MAX;
      byte_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      frame_en <= 1'b0;
      trunc    <= 1'b0;
      if (state == IDLE) begin
        credits <= CRED_MAX;
        bit_cnt <= '0;
      end else begin
        if (tx_valid && (bit_cnt != '1)) bit_cnt <= bit_nxt;
        if (fr_data_valid && !credit_ret)
          credits <= credits - 1'b1;
        else if (credit_ret && !fr_data_valid && (credits != CRED_MAX))
          credits <= credits + 1'b1;
      end
      case (state)
        IDLE: begin
          byte_cnt <= '0;
          if (frame_ready && (|req_valid)) begin
            g_idx    <= pick_idx;
            grant    <= N_REQ'(1) << pick_idx;
            frame_en <= 1'b1;
            state    <= START;
          end
        end
        START: state <= STREAM;
        STREAM: begin
          if (fr_data_valid) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (req_last[g_idx]) begin
              state <= DRAIN;
            end else if ((byte_cnt + 1'b1) == LEN_MAX) begin
              state <= DRAIN;
              trunc <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (frame_ready) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= (g_idx == LAST_IDX) ? '0 : g_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
